// File: rtl/i2c_pkg.sv
// i2c_pkg: types shared by the i2c arbiter slice.
//   addr_t      - 7-bit I2C slave address
//   opcode_t    - transaction direction (write = 0, read = 1)
//   arb_state_t - arbiter sequencer states
package i2c_pkg;

  typedef logic [6:0] addr_t;

  typedef enum logic {
    write = 1'b0,
    read  = 1'b1
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    RUN       = 3'd3,
    DONE      = 3'd4
  } arb_state_t;

endpackage

// File: rtl/i2c_arb_if.sv
// i2c_arb_if: requester-side and master-side signals of the i2c arbiter.
//   Requester side: req_valid/req_ready handshake with per-requester addr,
//   opcode and write data; rsp_valid (one-hot), rsp_err, shared rsp_data.
//   Master side: m_ain/m_opcode/m_din/m_vin towards the i2c master,
//   m_dout/m_vout/m_busy back from it.
// Modports:
//   master - the arbiter's view (drives req_ready, rsp_*, m_ain..m_vin)
//   slave  - the environment's view (requesters plus i2c master)
interface i2c_arb_if
  import i2c_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int BYTES_W = 3,
  parameter int BYTES_R = 3
) ();

  logic [N_REQ-1:0]                req_valid;
  logic [N_REQ-1:0]                req_ready;
  logic [N_REQ-1:0][6:0]           req_addr;
  logic [N_REQ-1:0]                req_opcode;
  logic [N_REQ-1:0][BYTES_W*8-1:0] req_data;
  logic [N_REQ-1:0]                rsp_valid;
  logic                            rsp_err;
  logic [BYTES_R*8-1:0]            rsp_data;
  addr_t                           m_ain;
  opcode_t                         m_opcode;
  logic [BYTES_W*8-1:0]            m_din;
  logic                            m_vin;
  logic [BYTES_R*8-1:0]            m_dout;
  logic                            m_vout;
  logic                            m_busy;

  modport master (
    input  req_valid, req_addr, req_opcode, req_data,
    input  m_dout, m_vout, m_busy,
    output req_ready, rsp_valid, rsp_err, rsp_data,
    output m_ain, m_opcode, m_din, m_vin
  );

  modport slave (
    output req_valid, req_addr, req_opcode, req_data,
    output m_dout, m_vout, m_busy,
    input  req_ready, rsp_valid, rsp_err, rsp_data,
    input  m_ain, m_opcode, m_din, m_vin
  );

endinterface

// File: rtl/i2c_rr_pick.sv
// i2c_rr_pick: combinational round-robin picker.
// Ports:
//   req_i   [N_REQ]  - request vector
//   last_i  [IDX_W]  - index granted most recently
//   found_o          - at least one request is set
//   idx_o   [IDX_W]  - first set request searching upward from last_i+1 (mod N_REQ)
module i2c_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             hit;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    found_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    hit      = 1'b0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand     = (int'(last_i) + i) % N_REQ;
      cand_idx = IDX_W'(cand);
      hit      = req_i[cand_idx];
      found_o  = found_o | hit;
      idx_o    = hit ? cand_idx : idx_o;
    end
  end

endmodule

// File: rtl/i2c_arb.sv
// i2c_arb: round-robin arbiter/sequencer sharing one i2c master among
// N_REQ requesters. A granted transaction is issued with a single m_vin
// strobe, tracked through m_busy, and answered with a one-hot rsp_valid.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - i2c_arb_if.master (requester handshake + master bus)
// Configuration:
//   I2C_ARB_TIMEOUT_EN - when defined, a watchdog ends a transaction after
//   TIMEOUT cycles in WAIT_BUSY/RUN with rsp_err=1; otherwise rsp_err is 0.
module i2c_arb
  import i2c_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int BYTES_W = 3,
  parameter int BYTES_R = 3,
  parameter int TIMEOUT = 65535
) (
  input logic        clk,
  input logic        rst_n,
  i2c_arb_if.master  bus
);

  localparam int IDX_W = $clog2(N_REQ);

  // Elaboration-time parameter sanity checks.
  if ((N_REQ < 2) || (N_REQ > 8)) begin : g_bad_n_req
    $error("i2c_arb: N_REQ must be within 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("i2c_arb: TIMEOUT must be at least 1");
  end

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return {{(N_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     g_q, g_d;
  addr_t                m_ain_q, m_ain_d;
  opcode_t              m_opcode_q, m_opcode_d;
  logic [BYTES_W*8-1:0] m_din_q, m_din_d;
  logic                 m_vin_q, m_vin_d;
  logic [N_REQ-1:0]     req_ready_q, req_ready_d;
  logic [N_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [BYTES_R*8-1:0] rsp_data_q, rsp_data_d;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  i2c_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (bus.req_valid),
    .last_i  (last_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Next-state and registered-output logic of the sequencer.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    g_d         = g_q;
    m_ain_d     = m_ain_q;
    m_opcode_d  = m_opcode_q;
    m_din_d     = m_din_q;
    m_vin_d     = 1'b0;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // A master still finishing an orphaned transaction blocks new grants.
        if (!bus.m_busy && pick_found) begin
          g_d         = pick_idx;
          m_ain_d     = bus.req_addr[pick_idx];
          m_opcode_d  = opcode_t'(bus.req_opcode[pick_idx]);
          m_din_d     = bus.req_data[pick_idx];
          rsp_data_d  = '0;
          m_vin_d     = 1'b1;
          req_ready_d = onehot(pick_idx);
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.m_busy) begin
          state_d = RUN;
        end else begin
          state_d = WAIT_BUSY;
        end
      end
      RUN: begin
        // Data arriving with the falling busy is still captured.
        if (bus.m_vout) begin
          rsp_data_d = bus.m_dout;
        end else begin
          rsp_data_d = rsp_data_q;
        end
        if (!bus.m_busy) begin
          state_d     = DONE;
          rsp_valid_d = onehot(g_q);
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        last_d  = g_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef I2C_ARB_TIMEOUT_EN
    if ((state_q == WAIT_BUSY) || (state_q == RUN)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        state_d     = DONE;
        rsp_valid_d = onehot(g_q);
        rsp_err_d   = 1'b1;
        rsp_data_d  = '0;
      end else begin
        rsp_err_d = 1'b0;
      end
    end else begin
      // Holding zero outside WAIT_BUSY/RUN clears it on entry to WAIT_BUSY.
      cnt_d = '0;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= IDX_W'(N_REQ - 1);
      g_q         <= '0;
      m_ain_q     <= '0;
      m_opcode_q  <= write;
      m_din_q     <= '0;
      m_vin_q     <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      g_q         <= g_d;
      m_ain_q     <= m_ain_d;
      m_opcode_q  <= m_opcode_d;
      m_din_q     <= m_din_d;
      m_vin_q     <= m_vin_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign bus.m_ain     = m_ain_q;
  assign bus.m_opcode  = m_opcode_q;
  assign bus.m_din     = m_din_q;
  assign bus.m_vin     = m_vin_q;
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
`ifdef I2C_ARB_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_arb.sv
// tb_i2c_arb: self-checking bench for i2c_arb (N_REQ=4, 3-byte payloads,
// TIMEOUT=100). A table of single transactions is replayed against a
// behavioural i2c master, followed by hand-written sequences for busy
// gating, round-robin contention, the watchdog and reset mid-transaction.
module tb_i2c_arb;
  import i2c_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  i2c_arb_if #(.N_REQ(4), .BYTES_W(3), .BYTES_R(3)) bus ();

  i2c_arb #(
    .N_REQ   (4),
    .BYTES_W (3),
    .BYTES_R (3),
    .TIMEOUT (100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          rq;
    logic [6:0]  addr;
    logic        op;
    logic [23:0] data;
    logic [23:0] dout;
    int          len;
    bit          at_fall;
    logic [3:0]  exp_oh;
    logic [23:0] exp_rsp;
  } vec_t;

  // behavioural master controls
  bit          auto_en;
  logic [23:0] mdl_dout;
  int          mdl_len;
  bit          mdl_at_fall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits for rsp_valid; n = cycles waited, or -1 if the bound expired.
  task automatic wait_rsp(input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      cyc();
      if (bus.rsp_valid != 4'b0000) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic clear_reqs();
    bus.req_valid  = '0;
    bus.req_addr   = '0;
    bus.req_opcode = '0;
    bus.req_data   = '0;
  endtask

  // Behavioural i2c master: busy follows the vin strobe, vout on reads.
  initial begin
    forever begin
      cyc();
      if (auto_en && bus.m_vin) begin
        automatic bit rd = (bus.m_opcode == read);
        cyc();
        bus.m_busy = 1'b1;
        for (int k = 1; k <= mdl_len; k++) begin
          if (k == mdl_len && rd && !mdl_at_fall) begin
            bus.m_vout = 1'b1;
            bus.m_dout = mdl_dout;
          end
          cyc();
          bus.m_vout = 1'b0;
        end
        bus.m_busy = 1'b0;
        if (rd && mdl_at_fall) begin
          bus.m_vout = 1'b1;
          bus.m_dout = mdl_dout;
        end
        cyc();
        bus.m_vout = 1'b0;
      end
    end
  end

  // Monitor: ready and vin always coincide; vin never while busy.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (bus.m_vin || (bus.req_ready != 4'b0000))) begin
        check("ready_vin_coincide", {62'd0, bus.m_vin, ($countones(bus.req_ready) == 1)}, 64'd3);
        if (bus.m_vin) check("vin_while_busy", {63'd0, bus.m_busy}, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog global time limit expired");
    $fatal(1, "time limit");
  end

  vec_t vecs[5];
  int   n;
  int   bad;
  int   exp_order[5];

  initial begin
    checks = 0;
    errors = 0;
    auto_en = 1'b0;
    mdl_dout = 24'h0;
    mdl_len = 2;
    mdl_at_fall = 1'b0;
    clear_reqs();
    bus.m_dout = '0;
    bus.m_vout = 1'b0;
    bus.m_busy = 1'b0;

    vecs[0] = '{0, 7'h41, 1'b0, 24'h05C5DD, 24'h123456, 3, 1'b0, 4'b0001, 24'h000000};
    vecs[1] = '{2, 7'h50, 1'b1, 24'h000000, 24'hABCDFF, 4, 1'b0, 4'b0100, 24'hABCDFF};
    vecs[2] = '{1, 7'h2A, 1'b1, 24'h000000, 24'h5A5A5A, 2, 1'b1, 4'b0010, 24'h5A5A5A};
    vecs[3] = '{3, 7'h7F, 1'b0, 24'hFFFFFF, 24'h000000, 2, 1'b0, 4'b1000, 24'h000000};
    vecs[4] = '{0, 7'h00, 1'b1, 24'h000000, 24'h000001, 5, 1'b0, 4'b0001, 24'h000001};
    exp_order = '{0, 1, 2, 3, 0};

    // reset
    rst_n = 1'b0;
    cyc(); cyc(); cyc();
    check("reset_ready", {60'd0, bus.req_ready}, 64'd0);
    check("reset_rsp_valid", {60'd0, bus.rsp_valid}, 64'd0);
    check("reset_vin", {63'd0, bus.m_vin}, 64'd0);
    check("reset_rsp_data", {40'd0, bus.rsp_data}, 64'd0);
    rst_n = 1'b1;
    cyc();

    // table-driven single transactions
    auto_en = 1'b1;
    foreach (vecs[i]) begin
      mdl_dout    = vecs[i].dout;
      mdl_len     = vecs[i].len;
      mdl_at_fall = vecs[i].at_fall;
      bus.req_valid[vecs[i].rq]  = 1'b1;
      bus.req_addr[vecs[i].rq]   = vecs[i].addr;
      bus.req_opcode[vecs[i].rq] = vecs[i].op;
      bus.req_data[vecs[i].rq]   = vecs[i].data;
      cyc();
      check("vec_ready", {60'd0, bus.req_ready}, {60'd0, vecs[i].exp_oh});
      check("vec_vin", {63'd0, bus.m_vin}, 64'd1);
      check("vec_ain", {57'd0, bus.m_ain}, {57'd0, vecs[i].addr});
      check("vec_opcode", {63'd0, bus.m_opcode}, {63'd0, vecs[i].op});
      check("vec_din", {40'd0, bus.m_din}, {40'd0, vecs[i].data});
      clear_reqs();
      wait_rsp(60, n);
      check("vec_rsp_latency", 64'(n), 64'(vecs[i].len + 2));
      check("vec_rsp_valid", {60'd0, bus.rsp_valid}, {60'd0, vecs[i].exp_oh});
      check("vec_rsp_data", {40'd0, bus.rsp_data}, {40'd0, vecs[i].exp_rsp});
      check("vec_rsp_err", {63'd0, bus.rsp_err}, 64'd0);
      check("vec_ain_hold", {57'd0, bus.m_ain}, {57'd0, vecs[i].addr});
      cyc();
      check("vec_rsp_pulse", {60'd0, bus.rsp_valid}, 64'd0);
    end
    auto_en = 1'b0;
    cyc(); cyc(); cyc();

    // busy gating: master already busy when req1 raises valid
    bus.m_busy = 1'b1;
    cyc();
    bus.req_valid[1] = 1'b1;
    bus.req_addr[1]  = 7'h33;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (bus.req_ready != 4'b0000 || bus.m_vin) bad++;
    end
    check("gate_no_ready_while_busy", 64'(bad), 64'd0);
    bus.m_busy = 1'b0;
    check("gate_no_ready_at_fall", {60'd0, bus.req_ready}, 64'd0);
    cyc();
    check("gate_ready_after_fall", {60'd0, bus.req_ready}, 64'd2);
    check("gate_ain", {57'd0, bus.m_ain}, 64'h33);
    clear_reqs();
    cyc();
    bus.m_busy = 1'b1;
    cyc(); cyc();
    bus.m_busy = 1'b0;
    wait_rsp(10, n);
    check("gate_rsp_valid", {60'd0, bus.rsp_valid}, 64'd2);
    cyc(); cyc();

    // contention from reset: all four valid, grants rotate 0,1,2,3,0
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      bus.req_valid[r] = 1'b1;
      bus.req_addr[r]  = 7'h10 + 7'(r);
      bus.req_data[r]  = 24'h100 * 24'(r + 1);
    end
    auto_en = 1'b1;
    mdl_len = 2;
    for (int t = 0; t < 5; t++) begin
      n = -1;
      for (int k = 1; k <= 40; k++) begin
        cyc();
        if (bus.m_vin) begin
          n = k;
          break;
        end
      end
      check("rr_vin_seen", 64'(n > 0), 64'd1);
      check("rr_grant", {60'd0, bus.req_ready}, 64'(4'b0001 << exp_order[t]));
      check("rr_ain", {57'd0, bus.m_ain}, 64'(7'h10 + 7'(exp_order[t])));
    end
    wait_rsp(20, n);
    clear_reqs();
    auto_en = 1'b0;
    cyc(); cyc(); cyc(); cyc();

    // watchdog: master never raises busy after req0 is issued
    bus.req_valid[0] = 1'b1;
    bus.req_addr[0]  = 7'h22;
    cyc();
    check("to_ready", {60'd0, bus.req_ready}, 64'd1);
    clear_reqs();
`ifdef I2C_ARB_TIMEOUT_EN
    wait_rsp(150, n);
    check("to_latency", 64'(n), 64'd101);
    check("to_rsp_valid", {60'd0, bus.rsp_valid}, 64'd1);
    check("to_rsp_err", {63'd0, bus.rsp_err}, 64'd1);
    check("to_rsp_data", {40'd0, bus.rsp_data}, 64'd0);
`else
    wait_rsp(150, n);
    check("to_stays_waiting", 64'(n), -64'sd1);
    bus.m_busy = 1'b1;
    cyc(); cyc();
    bus.m_busy = 1'b0;
    wait_rsp(10, n);
    check("to_late_rsp_valid", {60'd0, bus.rsp_valid}, 64'd1);
    check("to_late_rsp_err", {63'd0, bus.rsp_err}, 64'd0);
`endif
    cyc(); cyc();

    // reset in the middle of RUN
    bus.req_valid[2]  = 1'b1;
    bus.req_addr[2]   = 7'h50;
    bus.req_opcode[2] = 1'b1;
    cyc();
    check("mr_ready", {60'd0, bus.req_ready}, 64'd4);
    clear_reqs();
    cyc();
    bus.m_busy = 1'b1;
    cyc(); cyc();
    rst_n = 1'b0;
    #1;
    check("mr_async_vin_ain", {56'd0, bus.m_vin, bus.m_ain}, 64'd0);
    check("mr_async_rsp", {35'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 64'd0);
    check("mr_async_din_op", {39'd0, bus.m_opcode, bus.m_din}, 64'd0);
    bus.req_valid[0] = 1'b1;
    bus.req_addr[0]  = 7'h0A;
    bus.req_valid[3] = 1'b1;
    bus.req_addr[3]  = 7'h0D;
    cyc(); cyc(); cyc();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (bus.req_ready != 4'b0000) bad++;
    end
    check("mr_wait_busy_low", 64'(bad), 64'd0);
    bus.m_busy = 1'b0;
    cyc();
    check("mr_ready_req0", {60'd0, bus.req_ready}, 64'd1);
    check("mr_ain_req0", {57'd0, bus.m_ain}, 64'h0A);
    bus.req_valid[0] = 1'b0;
    cyc();
    bus.m_busy = 1'b1;
    cyc(); cyc();
    bus.m_busy = 1'b0;
    wait_rsp(10, n);
    bus.req_valid[3] = 1'b0;
    check("mr_rsp_valid", {60'd0, bus.rsp_valid}, 64'd1);
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
